// File: rtl/simd_muland_seq.sv
// Sequential SIMD AND / lane-wise modular multiply over WIDTH-bit operands.
// MUL: one LIMB x WIDTH partial product per cycle into carry-save regs, then one carry-propagate cycle.
module simd_muland_seq #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 32,
  localparam int N     = WIDTH / LIMB,
  localparam int LOG_N = $clog2(N),
  localparam int LSW   = LOG_N + 1,
  localparam int CW    = (N > 1) ? LOG_N : 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             mode_i,
  input  logic [LSW-1:0]   lane_sel_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] z_o
);

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q, sum_q, carry_q;
  logic [LSW-1:0]   ls_q;
  logic [CW-1:0]    cnt_q;

  logic [LSW-1:0]   ls_eff;
  logic [WIDTH-1:0] lane_mask, bnd, prod, pp, maj, sum_n, carry_n, res;
  logic [LIMB-1:0]  y_limb;
  logic [LIMB:0]    limb_sum;
  logic             cy;
  int               first_limb;

  // Lane selects beyond the operand width collapse to one full-width lane.
  assign ls_eff = (lane_sel_i > LSW'(LOG_N)) ? LSW'(LOG_N) : lane_sel_i;

  always_comb begin
    lane_mask  = '0;
    bnd        = '0;
    first_limb = (int'(cnt_q) >> ls_q) << ls_q;
    for (int k = 0; k < N; k++) begin
      if ((k >> ls_q) == (int'(cnt_q) >> ls_q)) lane_mask[k*LIMB +: LIMB] = '1;
      if ((k & ((1 << ls_q) - 1)) == 0) bnd[k*LIMB] = 1'b1;
    end
    y_limb  = y_q[int'(cnt_q)*LIMB +: LIMB];
    // x restricted to the active lane, weighted by this limb's offset inside the lane.
    prod    = (x_q & lane_mask) * WIDTH'(y_limb);
    pp      = (prod << ((int'(cnt_q) - first_limb) * LIMB)) & lane_mask;
    sum_n   = sum_q ^ carry_q ^ pp;
    maj     = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
    carry_n = (maj << 1) & ~bnd;
  end

  // Lane-segmented carry-propagate add: carry restarts at every lane base.
  always_comb begin
    res      = '0;
    cy       = 1'b0;
    limb_sum = '0;
    for (int k = 0; k < N; k++) begin
      if (bnd[k*LIMB]) cy = 1'b0;
      limb_sum = {1'b0, sum_q[k*LIMB +: LIMB]} + {1'b0, carry_q[k*LIMB +: LIMB]}
               + {{LIMB{1'b0}}, cy};
      res[k*LIMB +: LIMB] = limb_sum[LIMB-1:0];
      cy = limb_sum[LIMB];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      ls_q    <= '0;
      cnt_q   <= '0;
      ready_o <= 1'b1;
      valid_o <= 1'b0;
      z_o     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            x_q     <= x_i;
            y_q     <= y_i;
            ls_q    <= ls_eff;
            ready_o <= 1'b0;
            if (!mode_i) begin
              z_o     <= x_i & y_i;
              valid_o <= 1'b1;
              state_q <= DONE;
            end else begin
              sum_q   <= '0;
              carry_q <= '0;
              cnt_q   <= '0;
              state_q <= ACC;
            end
          end
        end
        ACC: begin
          sum_q   <= sum_n;
          carry_q <= carry_n;
          if (cnt_q == CW'(N - 1)) begin
            cnt_q   <= '0;
            state_q <= RESOLVE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESOLVE: begin
          z_o     <= res;
          valid_o <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (ready_i) begin
            z_o     <= '0;
            valid_o <= 1'b0;
            ready_o <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_muland_seq.sv
// Directed bench for simd_muland_seq: vector table plus backpressure and mid-operation reset sequences.
module tb_simd_muland_seq;
  localparam int W = 256;

  logic         clk_i = 1'b0;
  logic         rst_n_i, valid_i, ready_o, mode_i, valid_o, ready_i;
  logic [W-1:0] x_i, y_i, z_o;
  logic [3:0]   lane_sel_i;

  always #5 clk_i = ~clk_i;

  simd_muland_seq dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .x_i(x_i), .y_i(y_i), .mode_i(mode_i), .lane_sel_i(lane_sel_i),
    .valid_o(valid_o), .ready_i(ready_i), .z_o(z_o)
  );

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         mode;
    logic [3:0]   ls;
    logic [W-1:0] exp_z;
    int           exp_lat;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp_v);
    end
  endtask

  // Issues one operation, counts edges after the accept edge until valid_o, then takes the result.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                        input logic [3:0] ls, output logic [W-1:0] z, output int lat);
    int t = 0;
    while (!ready_o && t < 20) begin
      @(posedge clk_i); #1; t++;
    end
    if (!ready_o) chk("ready_timeout", {255'd0, ready_o}, 1);
    x_i = x; y_i = y; mode_i = m; lane_sel_i = ls; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; x_i = ~x; y_i = ~y; mode_i = ~m; lane_sel_i = ~ls;
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk_i); #1; lat++;
    end
    z = z_o;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
  endtask

  vec_t         vec [10];
  logic [W-1:0] z;
  int           lat;
  logic         saw_valid;

  initial begin
    vec[0] = '{{W{1'b1}}, 256'hA5, 1'b0, 4'd0, 256'hA5, 0};
    vec[1] = '{{8{32'hF0F0_1234}}, {8{32'h0FF0_FFFF}}, 1'b0, 4'd2, {8{32'h00F0_1234}}, 0};
    vec[2] = '{{8{32'hFFFF_FFFF}}, {8{32'd2}}, 1'b1, 4'd0, {8{32'hFFFF_FFFE}}, 9};
    vec[3] = '{{192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, {192'd0, 64'hFFFF_FFFF_FFFF_FFFF},
               1'b1, 4'd1, 256'd1, 9};
    vec[4] = '{{127'd0, 1'b1, 128'd0}, {127'd0, 1'b1, 128'd0}, 1'b1, 4'd3, 256'd0, 9};
    vec[5] = '{256'd3, 256'd5, 1'b1, 4'd3, 256'd15, 9};
    vec[6] = '{{128'hFFFF_FFFF, 128'h1_0000_0000_0000_0001},
               {128'h1_0000, 128'h1_0000_0000_0000_0001}, 1'b1, 4'd2,
               {128'hFFFF_FFFF_0000, 128'h2_0000_0000_0000_0001}, 9};
    vec[7] = '{{32'h8000_0000, 192'd0, 32'd3}, 256'd5, 1'b1, 4'd7,
               {32'h8000_0000, 192'd0, 32'd15}, 9};
    vec[8] = '{{160'd0, 32'hFFFF_FFFF, 32'h0001_0000, 32'h1234_5678},
               {160'd0, 32'hFFFF_FFFF, 32'h0001_0000, 32'd9}, 1'b1, 4'd0,
               {160'd0, 32'd1, 32'd0, 32'hA3D7_0A38}, 9};
    vec[9] = '{{128'd0, 64'h1_0000_0000, 64'hFFFF_FFFF},
               {128'd0, 64'h1_0000_0000, 64'hFFFF_FFFF}, 1'b1, 4'd1,
               {128'd0, 64'd0, 64'hFFFF_FFFE_0000_0001}, 9};

    rst_n_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; mode_i = 1'b0;
    x_i = '0; y_i = '0; lane_sel_i = '0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_valid_o", {255'd0, valid_o}, 0);
    chk("rst_ready_o", {255'd0, ready_o}, 1);
    chk("rst_z_o", z_o, 0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vec[i].x, vec[i].y, vec[i].mode, vec[i].ls, z, lat);
      chk($sformatf("vec%0d_z", i), z, vec[i].exp_z);
      chk($sformatf("vec%0d_lat", i), W'(lat), W'(vec[i].exp_lat));
    end

    // Backpressure: hold the result for 5 cycles while valid_i pokes at the block.
    x_i = {8{32'd3}}; y_i = {8{32'd7}}; mode_i = 1'b1; lane_sel_i = 4'd0; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk_i); #1; lat++;
    end
    for (int c = 0; c < 5; c++) begin
      valid_i = 1'b1; x_i = {8{32'hDEAD_BEEF}}; y_i = {8{32'h1234}}; mode_i = c[0];
      chk($sformatf("bp_z_c%0d", c), z_o, {8{32'd21}});
      chk($sformatf("bp_valid_c%0d", c), {255'd0, valid_o}, 1);
      chk($sformatf("bp_ready_c%0d", c), {255'd0, ready_o}, 0);
      @(posedge clk_i); #1;
    end
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
    chk("bp_release_valid", {255'd0, valid_o}, 0);
    chk("bp_release_z", z_o, 0);
    chk("bp_release_ready", {255'd0, ready_o}, 1);
    run_op({8{32'd10}}, {8{32'd11}}, 1'b1, 4'd0, z, lat);
    chk("bp_next_z", z, {8{32'd110}});
    chk("bp_next_lat", W'(lat), W'(9));

    // Reset while the limb counter sits at 4 in ACC.
    x_i = {8{32'hFFFF_FFFF}}; y_i = {8{32'd2}}; mode_i = 1'b1; lane_sel_i = 4'd0; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (4) begin
      @(posedge clk_i); #1;
    end
    rst_n_i = 1'b0;
    #1;
    chk("abort_valid", {255'd0, valid_o}, 0);
    chk("abort_z", z_o, 0);
    chk("abort_ready", {255'd0, ready_o}, 1);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk_i); #1;
      if (valid_o) saw_valid = 1'b1;
    end
    chk("abort_no_result", {255'd0, saw_valid}, 0);
    run_op({4{64'd6}}, {4{64'h1_0000_0001}}, 1'b1, 4'd1, z, lat);
    chk("after_abort_z", z, {4{64'h0000_0006_0000_0006}});
    chk("after_abort_lat", W'(lat), W'(9));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simd_muland_seq.md
SIMD_MULAND_SEQ -- requirements
Module: simd_muland_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 256: total operand width in bits; a multiple of LIMB.
REQ-002 SHALL have parameter LIMB, default 32: word width multiplied per cycle; N = WIDTH/LIMB SHALL be a power of two, N >= 1.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n_i, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port valid_i, input, 1: operands valid.
REQ-006 SHALL have port ready_o, output, 1: block can accept operands.
REQ-007 SHALL have port x_i, input, WIDTH: operand X.
REQ-008 SHALL have port y_i, input, WIDTH: operand Y.
REQ-009 SHALL have port mode_i, input, 1: 0 = AND, 1 = MUL.
REQ-010 SHALL have port lane_sel_i, input, clog2(N)+1: lane width = LIMB << lane_sel_i.
REQ-011 SHALL have port valid_o, output, 1: result valid.
REQ-012 SHALL have port ready_i, input, 1: consumer accepts the result.
REQ-013 SHALL have port z_o, output, WIDTH: result.

Function
REQ-014 SHALL implement states IDLE, ACC, RESOLVE, DONE.
REQ-015 SHALL drive ready_o = 1 only in IDLE, giving one operation in flight.
REQ-016 SHALL accept when valid_i && ready_o, latching x_i, y_i, mode_i and lane_sel_i; later input changes SHALL have no effect on the operation.
REQ-017 SHALL treat lane_sel_i > clog2(N) as lane width = WIDTH.
REQ-018 AND mode: SHALL go IDLE->DONE and set z = x & y; valid_o rises the cycle after acceptance.
REQ-019 MUL mode: SHALL go IDLE->ACC, then spend exactly N cycles in ACC, consuming y limb j in ACC cycle j (j = 0..N-1).
REQ-020 Each ACC cycle SHALL add one LIMB x WIDTH partial product into carry-save sum and carry registers (WIDTH bits each) using a 3:2 compressor, with no carry propagation.
REQ-021 SHALL restrict partial products to the lane of limb j; terms landing at or above the lane's upper boundary SHALL be discarded.
REQ-022 After ACC SHALL spend one RESOLVE cycle doing a carry-propagate add of sum and carry, killing carries at every lane boundary.
REQ-023 SHALL then enter DONE; MUL latency from acceptance to valid_o is N+1 cycles (9 at defaults).
REQ-024 MUL result per lane SHALL equal (x_lane * y_lane) mod 2^(lane width), with lanes independent.
REQ-025 In DONE, valid_o SHALL be 1 and z_o held stable until ready_i; on ready_i, SHALL go DONE->IDLE and drop valid_o.
REQ-026 valid_i while not in IDLE SHALL be ignored.
REQ-027 ready_o SHALL return high the cycle after the result handshake; there is no same-cycle accept during DONE.
REQ-028 z_o SHALL be 0 whenever valid_o = 0.
REQ-029 An internal limb counter SHALL count 0..N-1; at N = 1, ACC SHALL last one cycle.

Reset
REQ-030 rst_n_i low SHALL immediately force state IDLE, valid_o = 0, ready_o = 1, z_o = 0, and clear counter, sum, carry and operand registers.
REQ-031 Reset during ACC, RESOLVE or DONE SHALL abort the operation with no result emitted; the first operation after release SHALL be unaffected.

Verification
REQ-032 AND: x = all ones, y = 0x...00A5 -> z = y, valid_o one cycle after accept.
REQ-033 MUL, lane_sel = 0: every 32-bit lane x = 0xFFFFFFFF, y = 2 -> every lane 0xFFFFFFFE, valid_o 9 cycles after accept.
REQ-034 MUL, lane_sel = 1: lane0 x = y = 0xFFFFFFFFFFFFFFFF, other lanes 0 -> lane0 = 0x1, lanes 1-3 = 0 (no boundary carry leak).
REQ-035 MUL, lane_sel = 3: x = y = 2^128 -> z = 0 (wrap); x = 3, y = 5 -> z = 15.
REQ-036 Backpressure: ready_i low for 5 cycles in DONE -> z_o stable, ready_o = 0, interleaved valid_i ignored; next result correct.
REQ-037 Reset asserted in ACC cycle 4 -> valid_o = 0, z_o = 0, ready_o = 1; the following operation's result matches the reference model.
